fifo_ctrl_dp: RTL and testbench
===============================

// Module: fifo_ctrl_dp
// PURPOSE
//  Sequences a dual-port RAM (AW addr bits, DW data bits) as a synchronous FIFO.
//  Port A is write-only (push side) and port B is read-only (pop side).
//  Generates addresses, rw strobes, occupancy count, flags and error pulses.
//  Sits between a producer/consumer pair and one external RAM instance.
// PARAMETERS
//  AW            3    RAM address width; FIFO depth DEPTH = 2**AW
//  DW            4    data width
//  ALMOST_FULL   6    almost_full asserted when count >= ALMOST_FULL
//  ALMOST_EMPTY  2    almost_empty asserted when count <= ALMOST_EMPTY
// PORTS
//  clk           in   1     global clock, rising edge
//  reset         in   1     asynchronous, active-high reset
//  push          in   1     producer write request
//  push_data     in   DW    data to write
//  pop           in   1     consumer read request
//  pop_data      out  DW    read data (from RAM port B)
//  pop_valid     out  1     pop_data valid this cycle
//  full          out  1     count == DEPTH
//  empty         out  1     count == 0
//  almost_full   out  1     count >= ALMOST_FULL
//  almost_empty  out  1     count <= ALMOST_EMPTY
//  count         out  AW+1  current occupancy, 0..DEPTH
//  overflow      out  1     1-cycle pulse: push rejected while full
//  underflow     out  1     1-cycle pulse: pop rejected while empty
//  mem_addr_a    out  AW    RAM port A address (write pointer)
//  mem_rw_a      out  1     RAM port A mode; 0 = write, 1 = read/idle
//  mem_din_a     out  DW    RAM port A write data (= push_data)
//  mem_addr_b    out  AW    RAM port B address (read pointer)
//  mem_rw_b      out  1     RAM port B mode; tied 1 (read)
//  mem_dout_b    in   DW    RAM port B registered read data
// BEHAVIOUR
//  Reset (async, immediate): wr_ptr = rd_ptr = 0, count = 0, pop_valid = 0,
//  overflow = underflow = 0, state = EMPTY, mem_rw_a = 1. Flags follow count.
//  Accept rules, evaluated from registered state at the clock edge:
//   wr_en = push & (~full | pop); rd_en = pop & ~empty.
//  Push while full with pop in the same cycle is accepted (pass-through of slot).
//  wr_en: mem_rw_a = 0 combinationally; RAM writes mem_din_a at mem_addr_a
//  on that edge; wr_ptr += 1 (mod DEPTH, natural wrap).
//  rd_en: mem_addr_b = rd_ptr that cycle; rd_ptr += 1 mod DEPTH;
//  pop_valid = 1 on the next cycle with pop_data = mem_dout_b (1-cycle latency).
//  count: +1 on wr_en only, -1 on rd_en only, unchanged when both or neither.
//  Simultaneous push & pop on empty: push accepted, pop rejected (underflow).
//  overflow = push & full & ~pop; underflow = pop & empty; both registered 1-cycle.
//  FSM (occupancy state, drives flags):
//   EMPTY  -> NORMAL on wr_en & ~rd_en.
//   NORMAL -> FULL on count == DEPTH-1 & wr_en & ~rd_en.
//   NORMAL -> EMPTY on count == 1 & rd_en & ~wr_en.
//   FULL   -> NORMAL on rd_en & ~wr_en.
//  full / empty derive from the state; count must stay consistent with it.
//  Read/write to the same address in one cycle never occurs except as a
//  full-with-pop pass-through; the RAM is read-before-write there (old data out).
//  No data checking; RAM contents are not cleared by reset.
// STRUCTURE
//  Shared package/header fifo_defs.vh: state encodings (ST_EMPTY, ST_NORMAL,
//  ST_FULL) and RW_WRITE = 0 / RW_READ = 1 constants.
//  One natural sub-module: fifo_ptr (AW-bit wrapping pointer with inc enable),
//  instantiated twice (wr and rd). Everything else is in this module.
// TESTING (DEPTH=8, defaults, RAM model instanced)
//  1 reset mid-run with count=5 -> count=0, empty=1, pop_valid=0 immediately.
//  2 push 0x1..0x8 -> full=1 after 8th; almost_full from 6th; 9th push -> overflow pulse, count stays 8.
//  3 pop 8 from full -> pop_data 0x1..0x8 in order, each 1 cycle after pop; then pop -> underflow, no pop_valid.
//  4 fill 8, pop 4, push 4 -> wr_ptr wraps to 4; drain gives 0x5..0x8,new0..new3.
//  5 push&pop same cycle at count=3 -> count stays 3, data order preserved.
//  6 push&pop at full -> no overflow, count=8; push&pop at empty -> count=1, underflow pulse.

Source files
------------

// File: rtl/fifo_ctrl_dp_pkg.sv
// fifo_ctrl_dp_pkg: occupancy state encodings and RAM port mode constants
package fifo_ctrl_dp_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_NORMAL, ST_FULL} state_e;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ = 1'b1;
endpackage

// File: rtl/fifo_ctrl_dp_if.sv
// fifo_ctrl_dp_if: producer/consumer side of the FIFO controller
interface fifo_ctrl_dp_if #(parameter int AW = 3, parameter int DW = 4);
  logic push;
  logic [DW-1:0] push_data;
  logic pop;
  logic [DW-1:0] pop_data;
  logic pop_valid;
  logic full;
  logic empty;
  logic almost_full;
  logic almost_empty;
  logic [AW:0] count;
  logic overflow;
  logic underflow;
  modport master(output push, push_data, pop,
                 input pop_data, pop_valid, full, empty, almost_full, almost_empty, count, overflow, underflow);
  modport slave(input push, push_data, pop,
                output pop_data, pop_valid, full, empty, almost_full, almost_empty, count, overflow, underflow);
endinterface

// File: rtl/fifo_ctrl_dp_ptr.sv
// fifo_ctrl_dp_ptr: AW-bit wrapping pointer with increment enable
module fifo_ctrl_dp_ptr #(parameter int AW = 3) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);
  logic [AW-1:0] ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else ptr_q <= ptr_q + AW'(inc_i);
  assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_ctrl_dp.sv
// fifo_ctrl_dp: sequences a dual-port RAM as a synchronous FIFO (A = write, B = read)
module fifo_ctrl_dp
  import fifo_ctrl_dp_pkg::*;
#(
  parameter int AW = 3,
  parameter int DW = 4,
  parameter int ALMOST_FULL = 6,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic          clk,
  input  logic          rst,
  fifo_ctrl_dp_if.slave bus,
  output logic [AW-1:0] mem_addr_a_o,
  output logic          mem_rw_a_o,
  output logic [DW-1:0] mem_din_a_o,
  output logic [AW-1:0] mem_addr_b_o,
  output logic          mem_rw_b_o,
  input  logic [DW-1:0] mem_dout_b_i
);
  localparam int DEPTH = 2 ** AW;
  state_e state_q;
  logic [AW:0] count_q, count_d;
  logic pop_valid_q, overflow_q, underflow_q;
  logic full, empty, wr_en, rd_en;
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign full = state_q == ST_FULL;
  assign empty = state_q == ST_EMPTY;
  // a push into a full FIFO is still taken when a pop frees the slot this cycle
  assign wr_en = bus.push & (~full | bus.pop);
  assign rd_en = bus.pop & ~empty;
  assign count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_EMPTY;
      count_q <= '0;
      pop_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pop_valid_q <= rd_en;
      overflow_q <= bus.push & full & ~bus.pop;
      underflow_q <= bus.pop & empty;
      state_q <= (wr_en & ~rd_en) ? ((count_q == (AW+1)'(DEPTH-1)) ? ST_FULL : ST_NORMAL) :
                 (rd_en & ~wr_en) ? ((count_q == (AW+1)'(1)) ? ST_EMPTY : ST_NORMAL) : state_q;
    end
  fifo_ctrl_dp_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(rst), .inc_i(wr_en), .ptr_o(wr_ptr));
  fifo_ctrl_dp_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(rst), .inc_i(rd_en), .ptr_o(rd_ptr));
  assign mem_addr_a_o = wr_ptr;
  assign mem_rw_a_o = wr_en ? RW_WRITE : RW_READ;
  assign mem_din_a_o = bus.push_data;
  assign mem_addr_b_o = rd_ptr;
  assign mem_rw_b_o = RW_READ;
  assign bus.pop_data = mem_dout_b_i;
  assign bus.pop_valid = pop_valid_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = count_q >= (AW+1)'(ALMOST_FULL);
  assign bus.almost_empty = count_q <= (AW+1)'(ALMOST_EMPTY);
  assign bus.count = count_q;
  assign bus.overflow = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// tb_fifo_ctrl_dp: directed checks of fifo_ctrl_dp with a registered-read RAM model
module tb_fifo_ctrl_dp;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] addr_a, addr_b;
  logic rw_a, rw_b;
  logic [3:0] din_a, dout_b;
  logic [3:0] mem [8];
  int n_chk = 0;
  int n_fail = 0;
  fifo_ctrl_dp_if #(.AW(3), .DW(4)) bus ();
  fifo_ctrl_dp #(.AW(3), .DW(4), .ALMOST_FULL(6), .ALMOST_EMPTY(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mem_addr_a_o(addr_a), .mem_rw_a_o(rw_a), .mem_din_a_o(din_a),
    .mem_addr_b_o(addr_b), .mem_rw_b_o(rw_b), .mem_dout_b_i(dout_b)
  );
  always #5 clk = ~clk;
  // read-before-write RAM: port B registers the old word even on a same-address write
  always @(posedge clk) begin
    if (rw_a == 1'b0) mem[addr_a] <= din_a;
    if (rw_b == 1'b1) dout_b <= mem[addr_b];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic [3:0] d, input logic q);
    bus.push = p;
    bus.push_data = d;
    bus.pop = q;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_data = '0;
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_pop_valid", 32'(bus.pop_valid), 0);
    chk("rst_rw_a", 32'(rw_a), 1);
    chk("rst_rw_b", 32'(rw_b), 1);
    chk("rst_almost_empty", 32'(bus.almost_empty), 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // fill to full, watching the flags climb
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 4'(i), 1'b0);
      chk("fill_count", 32'(bus.count), 32'(i));
      chk("fill_almost_full", 32'(bus.almost_full), (i >= 6) ? 1 : 0);
      chk("fill_almost_empty", 32'(bus.almost_empty), (i <= 2) ? 1 : 0);
      chk("fill_full", 32'(bus.full), (i == 8) ? 1 : 0);
      chk("fill_empty", 32'(bus.empty), 0);
    end
    bus.push = 1'b1;
    #1;
    chk("full_push_rw_a", 32'(rw_a), 1);
    cyc(1'b1, 4'h9, 1'b0);
    chk("ovf_pulse", 32'(bus.overflow), 1);
    chk("ovf_count", 32'(bus.count), 8);
    chk("ovf_full", 32'(bus.full), 1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("ovf_clear", 32'(bus.overflow), 0);
    // drain in order, then pop on empty
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("drain_valid", 32'(bus.pop_valid), 1);
      chk("drain_data", 32'(bus.pop_data), 32'(i));
      chk("drain_count", 32'(bus.count), 32'(8 - i));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("udf_pulse", 32'(bus.underflow), 1);
    chk("udf_no_valid", 32'(bus.pop_valid), 0);
    chk("udf_count", 32'(bus.count), 0);
    cyc(1'b0, 4'h0, 1'b0);
    chk("udf_clear", 32'(bus.underflow), 0);
    // wrap: fill 8, pop 4, push 4 new, drain 8
    for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("wrap_pop_data", 32'(bus.pop_data), 32'(i));
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(4'hA + i), 1'b0);
    chk("wrap_wr_ptr", 32'(addr_a), 4);
    chk("wrap_rd_ptr", 32'(addr_b), 4);
    chk("wrap_full", 32'(bus.full), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("wrap_drain", 32'(bus.pop_data), (i < 4) ? 32'(5 + i) : 32'(4'hA + i - 4));
    end
    chk("wrap_empty", 32'(bus.empty), 1);
    // simultaneous push and pop at count 3
    for (int i = 1; i <= 3; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b1, 4'h4, 1'b1);
    chk("pp3_count_a", 32'(bus.count), 3);
    chk("pp3_data_a", 32'(bus.pop_data), 1);
    cyc(1'b1, 4'h5, 1'b1);
    chk("pp3_count_b", 32'(bus.count), 3);
    chk("pp3_data_b", 32'(bus.pop_data), 2);
    for (int i = 3; i <= 5; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("pp3_drain", 32'(bus.pop_data), 32'(i));
    end
    chk("pp3_empty", 32'(bus.empty), 1);
    // pass-through at full: old word comes out, new word takes its slot
    for (int i = 8; i <= 15; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b1, 4'h0, 1'b1);
    chk("ppf_no_ovf", 32'(bus.overflow), 0);
    chk("ppf_count", 32'(bus.count), 8);
    chk("ppf_full", 32'(bus.full), 1);
    chk("ppf_data", 32'(bus.pop_data), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'h0, 1'b1);
      chk("ppf_drain", 32'(bus.pop_data), (i < 7) ? 32'(9 + i) : 0);
    end
    // push and pop at empty: push taken, pop rejected
    cyc(1'b1, 4'h6, 1'b1);
    chk("ppe_count", 32'(bus.count), 1);
    chk("ppe_udf", 32'(bus.underflow), 1);
    chk("ppe_no_valid", 32'(bus.pop_valid), 0);
    chk("ppe_empty", 32'(bus.empty), 0);
    cyc(1'b0, 4'h0, 1'b1);
    chk("ppe_data", 32'(bus.pop_data), 6);
    chk("ppe_valid", 32'(bus.pop_valid), 1);
    chk("ppe_count0", 32'(bus.count), 0);
    // asynchronous reset mid-run at count 5 with pop_valid high
    for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i), 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    chk("pre_rst_count", 32'(bus.count), 5);
    chk("pre_rst_valid", 32'(bus.pop_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_empty", 32'(bus.empty), 1);
    chk("arst_valid", 32'(bus.pop_valid), 0);
    chk("arst_wr_ptr", 32'(addr_a), 0);
    chk("arst_rd_ptr", 32'(addr_b), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 4'h3, 1'b0);
    chk("post_rst_count", 32'(bus.count), 1);
    cyc(1'b0, 4'h0, 1'b1);
    chk("post_rst_data", 32'(bus.pop_data), 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
